// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: word size, NOP encoding, and the fetch entry
// carried from fetch into decode.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory address/data, execute redirect, halt,
// and the fetch-to-decode handshake.
interface instruction_fetch_if;
  import riscv_pkg::*;

  // Handshake: an entry transfers to decode on a rising edge where if_valid
  // and id_ready are both 1; id_ready while if_valid is 0 has no effect.
  // if_valid never depends combinationally on id_ready.
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instruction;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic            id_ready;
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;

  modport master (
    output pc, if_valid, if_instr, if_pc, if_pc_plus4,
    input  instruction, redirect_valid, redirect_pc, halt, id_ready
  );

  modport slave (
    input  pc, if_valid, if_instr, if_pc, if_pc_plus4,
    output instruction, redirect_valid, redirect_pc, halt, id_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch entries with synchronous flush; the caller
// guarantees no push when full unless a pop happens in the same cycle.
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, arbitrates redirect/halt/push/pop, and presents the
// buffered head entry to decode (NOP/0/4 when empty).
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus,
  output logic [1:0]          count
);

  logic [XLEN-1:0] pc_q;
  logic            push;
  logic            pop;
  logic            head_valid;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;
  logic [XLEN-1:0] head_pc;

  assign head_valid = (count != 2'd0);
  assign pop        = head_valid && bus.id_ready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign push       = !bus.redirect_valid && !bus.halt && ((count != 2'd2) || pop);

  always_ff @(posedge clk) begin
    if (!rst_n)                  pc_q <= word_align(RESET_PC);
    else if (bus.redirect_valid) pc_q <= word_align(bus.redirect_pc);
    else if (push)               pc_q <= pc_q + XLEN'(INSTR_BYTES);
  end

  assign wr_entry = '{pc: pc_q, instr: bus.instruction};

  fetch_buffer u_fetch_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (bus.redirect_valid),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  assign head_pc         = head_valid ? head.pc : '0;
  assign bus.pc          = pc_q;
  assign bus.if_valid    = head_valid;
  assign bus.if_instr    = head_valid ? head.instr : NOP_INSTR;
  assign bus.if_pc       = head_pc;
  assign bus.if_pc_plus4 = head_pc + XLEN'(INSTR_BYTES);

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that owns the program counter, drives the word-aligned address into the combinational instruction memory, and captures each returned instruction with its PC into a 2-entry buffer presented to decode through a valid/ready handshake. The stage sits directly upstream of the instruction memory (address side) and directly upstream of the decode stage (instruction side). Branch/jump redirects from execute flush the buffer and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; low two bits forced to 0
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- pc  output  32  fetch address to instruction memory; always word aligned
- instruction  input  32  combinational memory data for `pc`, valid in the same cycle
- redirect_valid  input  1  execute requests a PC change this cycle
- redirect_pc  input  32  target PC; bits [1:0] ignored, treated as 0
- halt  input  1  suppress new fetches; buffer still drains to decode
- id_ready  input  1  decode accepts the head entry this cycle
- if_valid  output  1  head entry present
- if_instr  output  32  head instruction
- if_pc  output  32  PC of head instruction
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32

## Operation
- State: pc register, 2-entry FIFO of {pc, instruction}, and a 2-bit count (0..2).
- push = !redirect_valid && !halt && (count < 2 || pop). pop = if_valid && id_ready.
- On push: entry {pc, instruction} is written at the tail and pc <= pc + 4, wrapping modulo 2^32. Memory-side wrap at its own depth is the memory's concern, not this block's.
- Push and pop in the same cycle: count unchanged. This applies at count 2, so throughput is 1/cycle when full.
- Pop with count 0 does not occur because if_valid = 0. id_ready while if_valid = 0 has no effect.
- Redirect has priority over all other events:
  - count <= 0 and all entries are discarded.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No push occurs that cycle, and any simultaneous pop is discarded with no side effect.
- halt: pc holds and no push occurs. Pops continue. A redirect during halt still loads pc and flushes the buffer.
- Head outputs (if_instr, if_pc, if_pc_plus4) are registered FIFO contents, not the combinational memory data. When if_valid = 0 they read 32'h0000_0013 (NOP), 0, and 4.
- Reset (rst_n = 0 at a clock edge): pc <= {RESET_PC[31:2], 2'b00}, count <= 0, if_valid = 0. This wins over redirect, halt, and pop, including a reset asserted mid-stream.

## Timing
- pc to if_valid latency: 1 cycle. The instruction read at pc in cycle N appears at the head in cycle N+1 if the FIFO was empty.
- After reset release at edge E0: pc = RESET_PC during cycle 0, and if_valid = 1 with if_pc = RESET_PC from cycle 1.
- Redirect asserted in cycle N: in cycle N+1, if_valid = 0 and pc = target. In cycle N+2, if_valid = 1 with if_pc = target. Two-cycle bubble.
- Sustained id_ready = 1 with no halt or redirect: one instruction per cycle, and if_pc increments by 4 each cycle.
- id_ready deasserted: the FIFO fills to 2, then pc stalls. The entry at pc stays unfetched until the next pop.
- No combinational path from id_ready or redirect_valid to pc or to the if_* outputs. Everything is registered.

## Structure
- Shared package riscv_pkg holds:
  - XLEN = 32, INSTR_BYTES = 4, NOP_INSTR = 32'h0000_0013.
  - A packed struct fetch_entry_t {pc[31:0], instr[31:0]}, reused by the decode-stage pipeline register.
- One sub-module, fetch_buffer: a 2-entry FIFO of fetch_entry_t with push/pop/flush and count.
- The top level keeps the pc register, push/pop/redirect arbitration, and the NOP/zero output defaults.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with RESET_PC = 32'h0000_0010, then release; id_ready = 1. Required: pc = 0x10 in cycle 0, if_pc = 0x10 in cycle 1, 0x14 in cycle 2, 0x18 in cycle 3, and if_valid = 0 throughout reset.
- Backpressure: id_ready = 0 for 5 cycles from reset release. Required: count reaches 2, pc stalls at RESET_PC + 8, and if_pc holds at RESET_PC. Then with id_ready = 1, the instructions at RESET_PC, +4, +8 appear on consecutive cycles with no gap or duplicate.
- Redirect with a full FIFO and a simultaneous pop: redirect_pc = 32'h0000_0043. Required: the next cycle has if_valid = 0 and pc = 0x40; the cycle after has if_pc = 0x40 and if_pc_plus4 = 0x44; the old entries never reappear.
- Halt: assert halt for 4 cycles with id_ready = 1. Required: the buffer drains within 2 cycles, then if_valid = 0 and pc is constant. On release, fetch resumes at the held pc.
- PC wrap: redirect to 32'hFFFF_FFFC. Required: if_pc sequence 0xFFFFFFFC then 0x00000000, with if_pc_plus4 = 0x00000000 for the first entry.
- Reset mid-stream while count = 2 and a redirect is asserted. Required: the next cycle shows if_valid = 0 and pc = RESET_PC; the redirect is ignored.
